// File: rtl/nonce_uart_reporter.sv
// nonce_uart_reporter: buffers nonce_found/nonce_out captures in a small FIFO
// and reports each nonce off-chip as a frame of 8N1 UART bytes, MSB byte first.
// Optional build macro NONCE_UART_CHECKSUM_EN appends a fifth byte holding the
// XOR of the four nonce bytes; without it each frame is exactly four bytes.
module nonce_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 32'd868,
  parameter int unsigned FIFO_DEPTH   = 32'd4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          nonce_found,
  input  logic [31:0]                   nonce_out,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 32'd1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
`ifdef NONCE_UART_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

`ifdef NONCE_UART_CHECKSUM_EN
  // XOR of the four bytes of a nonce, sent as the trailing check byte.
  function automatic logic [7:0] nonce_xor(input logic [31:0] v);
    nonce_xor = v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
  endfunction
`endif

  state_t          state_r, state_nx;
  logic [TW-1:0]   timer_r, timer_nx;
  logic [2:0]      bit_r, bit_nx;
  logic [2:0]      byte_r, byte_nx;
  logic [31:0]     shreg_r, shreg_nx;
`ifdef NONCE_UART_CHECKSUM_EN
  logic [7:0]      csum_r, csum_nx;
`endif
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            overflow_r;
  logic            tx_r, tx_nx;
  logic            busy_r;
  logic [31:0]     mem_r [FIFO_DEPTH];

  logic            timer_last_s;
  logic            frame_end_s;
  logic            pop_s;
  logic            push_s;
  logic [31:0]     head_s;
  logic [7:0]      cur_byte_s;

  assign timer_last_s = (timer_r == T_LAST);
  assign frame_end_s  = (state_r == STOP) && timer_last_s && (byte_r == LAST_BYTE);
  assign pop_s        = (count_r != {CW{1'b0}}) && ((state_r == IDLE) || frame_end_s);
  assign push_s       = nonce_found && ((count_r < DEPTH) || pop_s);
  assign head_s       = mem_r[rd_ptr_r];

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

  // Next-state, bit/byte sequencing and the registered value of the line.
  always_comb begin
    state_nx = state_r;
    timer_nx = timer_r + {{(TW-1){1'b0}}, 1'b1};
    bit_nx   = bit_r;
    byte_nx  = byte_r;
    shreg_nx = shreg_r;
`ifdef NONCE_UART_CHECKSUM_EN
    csum_nx  = csum_r;
`endif
    case (state_r)
      IDLE: begin
        timer_nx = {TW{1'b0}};
        if (pop_s) begin
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (timer_last_s) begin
          timer_nx = {TW{1'b0}};
          state_nx = DATA;
          bit_nx   = 3'd0;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (timer_last_s) begin
          timer_nx = {TW{1'b0}};
          if (bit_r == 3'd7) begin
            state_nx = STOP;
            bit_nx   = 3'd0;
          end else begin
            bit_nx   = bit_r + 3'd1;
          end
        end else begin
          state_nx = DATA;
        end
      end
      STOP: begin
        if (timer_last_s) begin
          timer_nx = {TW{1'b0}};
          if (byte_r != LAST_BYTE) begin
            state_nx = START;
            byte_nx  = byte_r + 3'd1;
            shreg_nx = {shreg_r[23:0], 8'h00};
          end else if (pop_s) begin
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = {TW{1'b0}};
      end
    endcase

    // A pop always begins a fresh frame from the FIFO head.
    if (pop_s) begin
      shreg_nx = head_s;
      byte_nx  = 3'd0;
      bit_nx   = 3'd0;
`ifdef NONCE_UART_CHECKSUM_EN
      csum_nx  = nonce_xor(head_s);
`endif
    end else begin
      shreg_nx = shreg_nx;
    end

`ifdef NONCE_UART_CHECKSUM_EN
    if (byte_nx == 3'd4) begin
      cur_byte_s = csum_nx;
    end else begin
      cur_byte_s = shreg_nx[31:24];
    end
`else
    cur_byte_s = shreg_nx[31:24];
`endif

    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = cur_byte_s[bit_nx];
      default: tx_nx = 1'b1;
    endcase
  end

  // FSM, timers, shift register, FIFO pointers/count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= {TW{1'b0}};
      bit_r      <= 3'd0;
      byte_r     <= 3'd0;
      shreg_r    <= 32'h0000_0000;
`ifdef NONCE_UART_CHECKSUM_EN
      csum_r     <= 8'h00;
`endif
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      timer_r    <= timer_nx;
      bit_r      <= bit_nx;
      byte_r     <= byte_nx;
      shreg_r    <= shreg_nx;
`ifdef NONCE_UART_CHECKSUM_EN
      csum_r     <= csum_nx;
`endif
      tx_r       <= tx_nx;
      busy_r     <= (state_nx != IDLE);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (nonce_found && !push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= nonce_out;
    end
  end

endmodule

// File: tb/tb_nonce_uart_reporter.sv
// Self-checking bench for nonce_uart_reporter (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A UART decoder turns tx back into bytes with their start cycles; a timing
// model predicts which nonces are accepted and when each frame starts.
module tb_nonce_uart_reporter;

  localparam int C = 4;
  localparam int D = 4;
`ifdef NONCE_UART_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int L = NB * 10 * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nonce_found = 1'b0;
  logic [31:0] nonce_out = 32'h0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  nonce_uart_reporter #(.CLKS_PER_BIT(32'd4), .FIFO_DEPTH(32'd4)) dut (
    .clk(clk), .reset(reset), .nonce_found(nonce_found), .nonce_out(nonce_out),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Edge counter: after edge k, cyc reads k on the following negedge.
  always @(posedge clk) cyc <= cyc + 1;

  // UART receive side: decoded bytes and the cycle their start bit began.
  logic [7:0] byte_q[$];
  int         st_q[$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_start = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [2:0] rx_bi;
  int         frame_err = 0;

  // Mid-bit sampling decoder on the falling clock edge.
  always @(negedge clk) begin
    if (reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1; rx_cnt = 0; rx_start = cyc; rx_byte = 8'h00;
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 9 * C + C / 2) begin
        if (tx !== 1'b1) frame_err++;
        byte_q.push_back(rx_byte);
        st_q.push_back(rx_start);
        rx_act = 1'b0;
      end else if (rx_cnt >= C + C / 2 && ((rx_cnt - C / 2) % C) == 0) begin
        rx_bi = 3'((rx_cnt - C - C / 2) / C);
        rx_byte[rx_bi] = tx;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int peak = 0;
  int exp_start[$];
  logic [31:0] exp_nonce[$];
  int sec_base = 0;
  bit m_ovf = 1'b0;
  int rx_rd = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy === 1'b1) busy_cnt++;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] v, input int b);
    logic [31:0] s;
    if (b == 4) return v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
    s = v >> (24 - 8 * b);
    return s[7:0];
  endfunction

  // Accept iff fewer than D accepted nonces are still waiting to start after edge t.
  task automatic model_write(input int t, input logic [31:0] v);
    int pend = 0;
    int s;
    for (int k = sec_base; k < exp_start.size(); k++)
      if (exp_start[k] > t) pend++;
    if (pend < D) begin
      s = t + 1;
      if (exp_start.size() > sec_base && exp_start[$] + L > s) s = exp_start[$] + L;
      exp_start.push_back(s);
      exp_nonce.push_back(v);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic pulse(input logic [31:0] v);
    nonce_found = 1'b1;
    nonce_out = v;
    model_write(cyc + 1, v);
    tick();
    nonce_found = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_section_done();
    if (exp_start.size() > sec_base) wait_until(exp_start[$] + L + 4);
    else wait_until(cyc + 4);
  endtask

  task automatic check_section(input string tag);
    for (int k = sec_base; k < exp_start.size(); k++) begin
      for (int b = 0; b < NB; b++) begin
        if (rx_rd < byte_q.size()) begin
          check({tag, " byte"}, byte_q[rx_rd], exp_byte(exp_nonce[k], b));
          check({tag, " start"}, st_q[rx_rd], exp_start[k] + b * 10 * C);
        end else begin
          check({tag, " missing byte"}, byte_q.size(), rx_rd + 1);
        end
        rx_rd++;
      end
    end
    check({tag, " byte count"}, byte_q.size(), rx_rd);
    check({tag, " framing"}, frame_err, 0);
    sec_base = exp_start.size();
  endtask

  int b0;
  int t0;
  int s0;

  initial begin
    // 1: reset held 3 cycles, then quiet line
    tick(); tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      check("idle tx", tx, 1'b1);
      check("idle busy", busy, 1'b0);
      check("idle fifo_count", fifo_count, 3'd0);
      check("idle overflow", overflow, 1'b0);
    end
    check("idle no bytes", byte_q.size(), 0);

    // 2: single nonce, latency, decode, busy length
    b0 = busy_cnt;
    t0 = cyc + 1;
    pulse(32'h12345678);
    check("t2 tx at N", tx, 1'b1);
    tick();
    check("t2 tx at N+1", tx, 1'b0);
    check("t2 start cycle", cyc, t0 + 1);
    wait_section_done();
    check_section("t2");
    check("t2 busy cycles", busy_cnt - b0, L);
    check("t2 fifo_count end", fifo_count, 3'd0);
`ifdef NONCE_UART_CHECKSUM_EN
    check("t2 checksum byte", byte_q[rx_rd - 1], 8'h08);
`endif

    // 3: six pulses every other cycle, sixth dropped
    peak = 0;
    check("t3 overflow before", overflow, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      pulse(32'(i));
      if (i < 6) tick();
    end
    check("t3 overflow after 6th", overflow, 1'b1);
    check("t3 model overflow", overflow, m_ovf);
    check("t3 accepted count", exp_start.size() - sec_base, 5);
    wait_section_done();
    check_section("t3");
    check("t3 peak fifo_count", peak, 4);
    check("t3 overflow sticky", overflow, 1'b1);

    // 4: back-to-back frames, no idle gap
    b0 = busy_cnt;
    pulse(32'hAAAAAAAA);
    pulse(32'h00000001);
    wait_section_done();
    check_section("t4");
    check("t4 frame gap", st_q[rx_rd - NB] - st_q[rx_rd - 2 * NB], L);
    check("t4 busy cycles", busy_cnt - b0, 2 * L);

    // 5: reset 50 cycles into a frame with two entries queued
    pulse(32'hC3A55A3C);
    pulse(32'h11111111);
    pulse(32'h22222222);
    s0 = exp_start[sec_base];
    wait_until(s0 + 49);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 tx", tx, 1'b1);
    check("t5 busy", busy, 1'b0);
    check("t5 fifo_count", fifo_count, 3'd0);
    check("t5 overflow", overflow, 1'b0);
    for (int i = 0; i < 500; i++) tick();
    check("t5 byte count", byte_q.size(), rx_rd + 1);
    if (rx_rd < byte_q.size()) begin
      check("t5 first byte", byte_q[rx_rd], 8'hC3);
      check("t5 first start", st_q[rx_rd], s0);
    end
    rx_rd = byte_q.size();
    check("t5 busy after", busy, 1'b0);
    sec_base = exp_start.size();
    m_ovf = 1'b0;

    // 6: random nonces with random gaps against the timing model
    for (int i = 0; i < 16; i++) begin
      pulse($urandom);
      for (int g = $urandom_range(0, 90); g > 0; g--) tick();
    end
    wait_section_done();
    check_section("rand");
    check("rand overflow", overflow, m_ovf);
    check("rand busy end", busy, 1'b0);
    check("rand fifo_count end", fifo_count, 3'd0);
    check("rand tx end", tx, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
